// File: rtl/rvc_asap_5pl_fetch.sv
// Fetch stage: owns the PC, aligns one-cycle-late instruction memory data with
// its PC and valid bit, holds it across decode stalls and kills wrong-path fetches.
module rvc_asap_5pl_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] I_MEM_MSB = 32'h0000_FFFF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        StallQ101H,
    input  logic        RedirectEnQ102H,
    input  logic [31:0] RedirectPcQ102H,
    output logic [31:0] PcQ100H,
    input  logic [31:0] IMemInstQ101H,
    output logic [31:0] InstructionQ101H,
    output logic [31:0] PcQ101H,
    output logic        ValidQ101H,
    output logic        FetchFaultQ101H
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc101_q, pc101_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [32:0] last_byte;
    logic        fault_now;

    // 33-bit sum so a fetch straddling 2^32 is reported as a fault
    assign last_byte = {1'b0, pc_q} + 33'd3;
    assign fault_now = last_byte > {1'b0, I_MEM_MSB};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc101_d     = pc101_q;
        hold_inst_d = hold_inst_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        if (RedirectEnQ102H) begin
            pc_d    = {RedirectPcQ102H[31:2], 2'b00};
            pc101_d = pc_q;
            valid_d = 1'b0;
            fault_d = 1'b0;
            state_d = KILL;
        end else begin
            unique case (state_q)
                KILL: begin
                    // Memory output this cycle is old-path data; the target
                    // address stays on the bus one more edge so it is not lost.
                    pc101_d = pc_q;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    state_d = RUN;
                end
                HOLD: begin
                    if (!StallQ101H) begin
                        pc_d    = pc_q + 32'd4;
                        pc101_d = pc_q;
                        valid_d = 1'b1;
                        fault_d = fault_now;
                        state_d = RUN;
                    end
                end
                default: begin
                    if (StallQ101H) begin
                        hold_inst_d = IMemInstQ101H;
                        state_d     = HOLD;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        pc101_d = pc_q;
                        valid_d = 1'b1;
                        fault_d = fault_now;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            pc101_q     <= 32'h0;
            hold_inst_q <= 32'h0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc101_q     <= pc101_d;
            hold_inst_q <= hold_inst_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
        end
    end

    assign PcQ100H          = pc_q;
    assign PcQ101H          = pc101_q;
    assign ValidQ101H       = valid_q;
    assign FetchFaultQ101H  = fault_q;
    assign InstructionQ101H = (state_q == HOLD) ? hold_inst_q : IMemInstQ101H;

endmodule
